// File: rtl/memory_system_pkg.sv
// Shared definitions for the memory_system datapath and its control unit:
// register addresses, ALU operation codes, opcodes and the control FSM states.
package memory_system_pkg;

  localparam logic [2:0] REG_PC   = 3'd0;
  localparam logic [2:0] REG_DPTR = 3'd1;
  localparam logic [2:0] REG_A    = 3'd2;
  localparam logic [2:0] REG_TEMP = 3'd3;
  localparam logic [2:0] REG_ACC  = 3'd4;

  typedef enum logic [2:0] {
    SEL_PASSB = 3'b000,
    SEL_ADD   = 3'b001,
    SEL_SUB   = 3'b010,
    SEL_AND   = 3'b011,
    SEL_SHL   = 3'b100,
    SEL_INCB  = 3'b101
  } selop_t;

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_LD  = 3'b001,
    OP_ST  = 3'b010,
    OP_ADD = 3'b011,
    OP_SUB = 3'b100,
    OP_AND = 3'b101,
    OP_SHL = 3'b110,
    OP_JZ  = 3'b111
  } opcode_t;

  // IDLE must stay at zero: the debug state output reads 0 out of reset.
  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_F0   = 4'd1,
    ST_F1   = 4'd2,
    ST_F2   = 4'd3,
    ST_F3   = 4'd4,
    ST_DEC  = 4'd5,
    ST_L0   = 4'd6,
    ST_L1   = 4'd7,
    ST_L2   = 4'd8,
    ST_L3   = 4'd9,
    ST_S0   = 4'd10,
    ST_S1   = 4'd11,
    ST_S2   = 4'd12,
    ST_X0   = 4'd13,
    ST_J0   = 4'd14
  } state_t;

  typedef struct packed {
    logic       ir_sclr;
    logic       mar_sclr;
    logic [2:0] busb_addr;
    logic [2:0] busc_addr;
    logic [2:0] selop;
    logic [1:0] shamt;
    logic       mdr_alu_n;
    logic       enaf;
    logic       ir_en;
    logic       mar_en;
    logic       mdr_en;
    logic       bank_wr_en;
    logic       wr_rdn;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  function automatic logic [2:0] alu_selop(input opcode_t op);
    logic [2:0] sel;
    sel = SEL_PASSB;
    case (op)
      OP_ADD:  sel = SEL_ADD;
      OP_SUB:  sel = SEL_SUB;
      OP_AND:  sel = SEL_AND;
      OP_SHL:  sel = SEL_SHL;
      default: sel = SEL_PASSB;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/control_unit.sv
// Moore control FSM for the memory_system datapath: fetch, decode and the
// per-opcode execute micro-steps. All control outputs decode from the state.
module control_unit
  import memory_system_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [DATA_WIDTH-4:0] instruction,
  input  logic                  C,
  input  logic                  N,
  input  logic                  P,
  input  logic                  Z,
  output logic                  ir_sclr,
  output logic                  mar_sclr,
  output logic [2:0]            busB_addr,
  output logic [2:0]            busC_addr,
  output logic [2:0]            selop,
  output logic [1:0]            shamt,
  output logic                  mdr_alu_n,
  output logic                  enaf,
  output logic                  ir_en,
  output logic                  mar_en,
  output logic                  mdr_en,
  output logic                  bank_wr_en,
  output logic                  wr_rdn,
  output logic                  busy,
  output logic [3:0]            state
);

  state_t     state_q;
  state_t     state_d;
  state_t     end_next;
  opcode_t    opcode;
  logic [1:0] operand;
  ctrl_t      ctrl;
  logic       unused_flags;

  assign opcode       = opcode_t'(instruction[DATA_WIDTH-4 -: 3]);
  assign operand      = instruction[1:0];
  assign unused_flags = ^{C, N, P};

  // run is only consulted here and in IDLE, so a dropped run finishes the instruction.
  assign end_next = run ? ST_F0 : ST_IDLE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (run) state_d = ST_F0;
      ST_F0:   state_d = ST_F1;
      ST_F1:   state_d = ST_F2;
      ST_F2:   state_d = ST_F3;
      ST_F3:   state_d = ST_DEC;
      ST_DEC: begin
        case (opcode)
          OP_NOP:  state_d = end_next;
          OP_LD:   state_d = ST_L0;
          OP_ST:   state_d = ST_S0;
          OP_JZ:   state_d = ST_J0;
          default: state_d = ST_X0;
        endcase
      end
      ST_L0:   state_d = ST_L1;
      ST_L1:   state_d = ST_L2;
      ST_L2:   state_d = ST_L3;
      ST_L3:   state_d = end_next;
      ST_S0:   state_d = ST_S1;
      ST_S1:   state_d = ST_S2;
      ST_S2:   state_d = end_next;
      ST_X0:   state_d = end_next;
      ST_J0:   state_d = end_next;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ctrl = CTRL_NONE;
    case (state_q)
      ST_IDLE: begin
        ctrl.ir_sclr  = 1'b1;
        ctrl.mar_sclr = 1'b1;
      end
      ST_F0: begin
        ctrl.busb_addr = REG_PC;
        ctrl.selop     = SEL_PASSB;
        ctrl.mar_en    = 1'b1;
      end
      // RAM read of the fetched address overlaps the PC increment.
      ST_F1: begin
        ctrl.busb_addr  = REG_PC;
        ctrl.selop      = SEL_INCB;
        ctrl.busc_addr  = REG_PC;
        ctrl.bank_wr_en = 1'b1;
      end
      ST_F2: begin
        ctrl.mdr_en    = 1'b1;
        ctrl.mdr_alu_n = 1'b1;
      end
      ST_F3: begin
        ctrl.mdr_alu_n = 1'b1;
        ctrl.ir_en     = 1'b1;
      end
      ST_L0, ST_S0: begin
        ctrl.busb_addr = REG_DPTR;
        ctrl.selop     = SEL_PASSB;
        ctrl.mar_en    = 1'b1;
      end
      ST_L2: begin
        ctrl.mdr_en    = 1'b1;
        ctrl.mdr_alu_n = 1'b1;
      end
      ST_L3: begin
        ctrl.mdr_alu_n  = 1'b1;
        ctrl.busc_addr  = REG_A;
        ctrl.bank_wr_en = 1'b1;
      end
      ST_S1: begin
        ctrl.busb_addr = REG_A;
        ctrl.selop     = SEL_PASSB;
        ctrl.mdr_en    = 1'b1;
      end
      ST_S2: begin
        ctrl.wr_rdn = 1'b1;
      end
      ST_X0: begin
        ctrl.busb_addr  = {1'b0, operand};
        ctrl.selop      = alu_selop(opcode);
        ctrl.shamt      = (opcode == OP_SHL) ? operand : 2'b00;
        ctrl.enaf       = 1'b1;
        ctrl.busc_addr  = REG_ACC;
        ctrl.bank_wr_en = 1'b1;
      end
      // A taken jump rewrites the PC that F1 already incremented.
      ST_J0: begin
        if (Z) begin
          ctrl.busb_addr  = REG_DPTR;
          ctrl.selop      = SEL_PASSB;
          ctrl.busc_addr  = REG_PC;
          ctrl.bank_wr_en = 1'b1;
        end
      end
      default: ctrl = CTRL_NONE;
    endcase
  end

  assign ir_sclr    = ctrl.ir_sclr;
  assign mar_sclr   = ctrl.mar_sclr;
  assign busB_addr  = ctrl.busb_addr;
  assign busC_addr  = ctrl.busc_addr;
  assign selop      = ctrl.selop;
  assign shamt      = ctrl.shamt;
  assign mdr_alu_n  = ctrl.mdr_alu_n;
  assign enaf       = ctrl.enaf;
  assign ir_en      = ctrl.ir_en;
  assign mar_en     = ctrl.mar_en;
  assign mdr_en     = ctrl.mdr_en;
  assign bank_wr_en = ctrl.bank_wr_en;
  assign wr_rdn     = ctrl.wr_rdn;
  assign busy       = (state_q != ST_IDLE);
  assign state      = state_q;

  assert property (@(posedge clk) disable iff (!rst) !(wr_rdn && bank_wr_en));

endmodule

// File: doc/control_unit.md
# control_unit

Microprogrammed control FSM that drives the `memory_system` datapath. It sequences instruction fetch (MAR←PC, RAM read, MDR, IR, PC+1), decodes the opcode field of `instruction`, and issues per-instruction execute micro-steps. It consumes the datapath's instruction and flag outputs and produces every control input the datapath takes. It sits beside `memory_system` in the CPU top.

## Interface
- `DATA_WIDTH`, 8, datapath width; instruction width is `DATA_WIDTH-3`.
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — asynchronous, active-low reset.
- `run` in 1 — level; high allows fetch to start and continue.
- `instruction` in `DATA_WIDTH-3` — IR contents; opcode = top 3 bits, operand = bits [1:0].
- `C`, `N`, `P`, `Z` in 1 each — registered ALU flags.
- `ir_sclr`, `mar_sclr` out 1 — synchronous clear of IR and MAR.
- `busB_addr`, `busC_addr` out 3 — register-bank read and write addresses.
- `selop` out 3, `shamt` out 2 — ALU operation and shift amount.
- `mdr_alu_n` out 1 — 1: MDR loads RAM data and drives busC; 0: ALU drives busC and feeds MDR.
- `enaf`, `ir_en`, `mar_en`, `mdr_en`, `bank_wr_en`, `wr_rdn` out 1 each — datapath enables; `wr_rdn` = RAM write.
- `busy` out 1 — state ≠ IDLE.
- `state` out 4 — current state encoding, for debug.

## Operation
- Moore FSM. All outputs decode from the state register, plus `Z` in J0. An output not listed for a state is 0.
- Register addresses: PC=0, DPTR=1, A=2, TEMP=3, ACC=4. busA is hard-wired to ACC.
- `selop` codes: PASSB=000, ADD=001, SUB=010, AND=011, SHL=100, INCB=101.
- Opcodes: NOP=000, LD=001, ST=010, ADD=011, SUB=100, AND=101, SHL=110, JZ=111.
- IDLE: `ir_sclr`=`mar_sclr`=1. If `run`, go to F0.
- F0: busB=PC, PASSB, `mdr_alu_n`=0, `mar_en`. Next: F1.
- F1: RAM read cycle. busB=PC, INCB, busC=PC, `bank_wr_en`. Next: F2.
- F2: `mdr_en`, `mdr_alu_n`=1. Next: F3.
- F3: `mdr_alu_n`=1, `ir_en`. Next: DEC.
- DEC: no outputs. Branches on opcode: NOP→END; LD→L0; ST→S0; ADD/SUB/AND/SHL→X0; JZ→J0.
- L0: busB=DPTR, PASSB, `mar_en`.
- L1: wait.
- L2: `mdr_en`, `mdr_alu_n`=1.
- L3: `mdr_alu_n`=1, busC=A, `bank_wr_en`. Next: END.
- S0: as L0.
- S1: busB=A, PASSB, `mdr_alu_n`=0, `mdr_en`.
- S2: `wr_rdn`. Next: END.
- X0: busB=operand, selop per opcode, `shamt`=operand (SHL only; otherwise 0), `enaf`, busC=ACC, `bank_wr_en`, `mdr_alu_n`=0. Next: END.
- J0: if `Z`, busB=DPTR, PASSB, busC=PC, `bank_wr_en`, `mdr_alu_n`=0. Otherwise no writes. Next: END.
- END is a transition rule, not a state: go to F0 if `run`, else IDLE.
- `run` is sampled only in IDLE and at END. Dropping `run` mid-instruction completes the instruction.

## Timing
- Reset: state=IDLE, `busy`=0, `state`=0, `ir_sclr`=`mar_sclr`=1, every other output 0.
- RAM read is synchronous with one-cycle latency: address in MAR at F0 edge → data valid during F2.
- Fetch takes 4 cycles (F0–F3), decode 1.
- Execute lengths: NOP 0, LD 4, ST 3, ALU ops 1, JZ 1.
- Instruction totals, back-to-back under continuous `run`: NOP 5, ALU/JZ 6, ST 8, LD 9 cycles.
- PC increments exactly once per instruction, in F1. A JZ taken overrides it with DPTR.
- JZ uses `Z` as registered at the end of the last `enaf` cycle. Flags are not updated in any other state.
- `wr_rdn` and `bank_wr_en` are never asserted in the same cycle.
- Async reset asserted mid-instruction (e.g. during S2) drops `wr_rdn` immediately. No partial write completes after reset.

## Structure
- Shared package `memory_system_pkg`: register-address constants, `selop` codes, opcode constants, state enum.
- Single module with no sub-modules. The opcode→selop map is a function in the package.

## Test plan
- Reset then `run`=0 for 10 cycles → state stays IDLE; `busy`=0; `ir_sclr`=`mar_sclr`=1; no `bank_wr_en`.
- `run`=1, `instruction` opcode NOP → `mar_en` at cycle 1, PC write at 2, `ir_en` at 4, next `mar_en` at cycle 6.
- Opcode ADD, operand=3 → X0 drives busB=3, busC=4, `selop`=001, `enaf`=1, `bank_wr_en`=1 for exactly 1 cycle.
- Opcode ST → S2 asserts `wr_rdn` for exactly 1 cycle, 3 cycles after DEC; `mdr_alu_n`=0 in S1.
- Opcode JZ with `Z`=1 → PC written from DPTR in J0. With `Z`=0 → no `bank_wr_en` in J0.
- LD in progress, `run` dropped in L1 → L2, L3 complete and A is written; then IDLE. Reset pulse in L2 → IDLE immediately with all enables 0.
